// File: rtl/rc_car_pkg.sv
// Shared encodings for the RC-car drive controller: motion states and UART
// keyboard command bytes.
package rc_car_pkg;

    typedef enum logic [2:0] {
        STOP     = 3'd0,
        FORWARD  = 3'd1,
        BACKWARD = 3'd2,
        GO_LEFT  = 3'd3,
        GO_RIGHT = 3'd4
    } state_e;

    localparam logic [7:0] CMD_UP     = 8'h71;
    localparam logic [7:0] CMD_DOWN   = 8'h77;
    localparam logic [7:0] CMD_LEFT   = 8'h65;
    localparam logic [7:0] CMD_RIGHT  = 8'h72;
    localparam logic [7:0] CMD_ESTOP  = 8'h20;
    localparam logic [7:0] CMD_SPD_UP = 8'h2B;
    localparam logic [7:0] CMD_SPD_DN = 8'h2D;

endpackage

// File: rtl/rc_pwm_gen.sv
// PWM compare against a shared free-running counter; output is forced low
// when the channel is disabled.
module rc_pwm_gen #(
    parameter int unsigned PWM_W = 8
) (
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] duty,
    input  logic             en,
    output logic             pwm
);

    always_comb begin
        pwm = en && (cnt < duty);
    end

endmodule

// File: rtl/rc_drive_controller.sv
// RC-car drive controller: command decoder, speed level, crash latch, command
// watchdog and registered two-channel PWM/direction outputs.
module rc_drive_controller
    import rc_car_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned SPEED_W        = 3,
    parameter int unsigned PWM_W          = 8,
    parameter int unsigned N_SENS         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic [N_SENS-1:0]  sens,
    output logic [2:0]         state,
    output logic [SPEED_W-1:0] speed,
    output logic               crash,
    output logic               timeout,
    output logic               pwm_l,
    output logic               pwm_r,
    output logic               dir_l,
    output logic               dir_r
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SPEED_W-1:0] SPEED_RST = SPEED_W'(1) << (SPEED_W - 1);
    localparam logic [SPEED_W-1:0] SPEED_MIN = SPEED_W'(1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

    state_e              state_q, state_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic                crash_q, crash_d;
    logic                timeout_q, timeout_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [PWM_W-1:0]    cnt_q, cnt_d;
    logic [N_SENS-1:0]   sync1_q, sync2_q;
    logic                pwm_l_q, pwm_l_d;
    logic                pwm_r_q, pwm_r_d;
    logic                dir_l_q, dir_l_d;
    logic                dir_r_q, dir_r_d;

    logic             hit;
    logic             crash_set;
    logic             wd_expire;
    logic [PWM_W-1:0] duty;
    logic             pwm_raw;

    rc_pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm_gen (
        .cnt  (cnt_q),
        .duty (duty),
        .en   (state_q != STOP),
        .pwm  (pwm_raw)
    );

    always_comb begin
        hit       = |sync2_q;
        crash_set = hit && (state_q == FORWARD);
        // Fires one cycle early so STOP lands exactly TIMEOUT_CYCLES after the last command.
        wd_expire = (state_q != STOP) && (wd_q == WD_W'(TIMEOUT_CYCLES - 2));
        duty      = PWM_W'(speed_q) << (PWM_W - SPEED_W);
        cnt_d     = cnt_q + PWM_W'(1);

        state_d   = state_q;
        speed_d   = speed_q;
        crash_d   = crash_q;
        timeout_d = 1'b0;
        wd_d      = (state_q == STOP) ? '0 : wd_q + WD_W'(1);

        if (crash_set) begin
            state_d = STOP;
            crash_d = 1'b1;
            wd_d    = '0;
        end else if (wd_expire) begin
            state_d   = STOP;
            timeout_d = 1'b1;
            wd_d      = '0;
        end else if (rx_valid) begin
            case (rx_data)
                CMD_UP: begin
                    // Forward is locked out until a reverse clears the crash.
                    if (!crash_q) begin
                        state_d = FORWARD;
                        wd_d    = '0;
                    end
                end
                CMD_DOWN: begin
                    state_d = BACKWARD;
                    crash_d = 1'b0;
                    wd_d    = '0;
                end
                CMD_LEFT: begin
                    state_d = GO_LEFT;
                    wd_d    = '0;
                end
                CMD_RIGHT: begin
                    state_d = GO_RIGHT;
                    wd_d    = '0;
                end
                CMD_ESTOP: begin
                    state_d = STOP;
                    wd_d    = '0;
                end
                CMD_SPD_UP: begin
                    if (speed_q != SPEED_MAX) speed_d = speed_q + SPEED_W'(1);
                    wd_d = '0;
                end
                CMD_SPD_DN: begin
                    if (speed_q > SPEED_MIN) speed_d = speed_q - SPEED_W'(1);
                    wd_d = '0;
                end
                default: ;
            endcase
        end

        pwm_l_d = pwm_raw && (state_q inside {FORWARD, BACKWARD, GO_RIGHT});
        pwm_r_d = pwm_raw && (state_q inside {FORWARD, BACKWARD, GO_LEFT});
        dir_l_d = (state_q != BACKWARD);
        dir_r_d = (state_q != BACKWARD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STOP;
            speed_q   <= SPEED_RST;
            crash_q   <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            cnt_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            pwm_l_q   <= 1'b0;
            pwm_r_q   <= 1'b0;
            dir_l_q   <= 1'b1;
            dir_r_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            crash_q   <= crash_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            cnt_q     <= cnt_d;
            sync1_q   <= sens;
            sync2_q   <= sync1_q;
            pwm_l_q   <= pwm_l_d;
            pwm_r_q   <= pwm_r_d;
            dir_l_q   <= dir_l_d;
            dir_r_q   <= dir_r_d;
        end
    end

    assign state   = state_q;
    assign speed   = speed_q;
    assign crash   = crash_q;
    assign timeout = timeout_q;
    assign pwm_l   = pwm_l_q;
    assign pwm_r   = pwm_r_q;
    assign dir_l   = dir_l_q;
    assign dir_r   = dir_r_q;

endmodule

// File: tb/tb_rc_drive_controller.sv
// Directed bench for rc_drive_controller with a short watchdog (100 cycles).
module tb_rc_drive_controller;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [1:0] sens;
    logic [2:0] state;
    logic [2:0] speed;
    logic       crash;
    logic       timeout;
    logic       pwm_l;
    logic       pwm_r;
    logic       dir_l;
    logic       dir_r;

    int n_checks = 0;
    int n_pass   = 0;

    rc_drive_controller #(
        .TIMEOUT_CYCLES (100),
        .SPEED_W        (3),
        .PWM_W          (8),
        .N_SENS         (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .sens     (sens),
        .state    (state),
        .speed    (speed),
        .crash    (crash),
        .timeout  (timeout),
        .pwm_l    (pwm_l),
        .pwm_r    (pwm_r),
        .dir_l    (dir_l),
        .dir_r    (dir_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Counts PWM high cycles over one full period, re-sending keep to hold off the watchdog.
    task automatic measure(input logic [7:0] keep, output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hl += int'(pwm_l);
            hr += int'(pwm_r);
            if (i % 64 == 0) begin
                rx_valid = 1'b1;
                rx_data  = keep;
            end else begin
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic crash_pulse(input logic [1:0] v);
        @(negedge clk);
        sens = v;
        @(negedge clk);
        @(negedge clk);
        check("crash_lat2", crash, 0);
        @(negedge clk);
        check("crash_lat3", crash, 1);
        check("crash_state", state, 0);
        sens = '0;
    endtask

    // Sends cmd, optionally injects a second byte at cycle inj, returns cycle of timeout pulse.
    task automatic wd_run(input logic [7:0] cmd, input int inj, input logic [7:0] inj_b,
                          output int cyc_to, output logic [2:0] mid_state);
        @(negedge clk);
        rx_valid  = 1'b1;
        rx_data   = cmd;
        cyc_to    = -1;
        mid_state = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) rx_valid = 1'b0;
            if (c == inj) begin
                rx_valid = 1'b1;
                rx_data  = inj_b;
            end else if (c == inj + 1) begin
                rx_valid = 1'b0;
            end
            if (c == inj + 10) mid_state = state;
            if (timeout) begin
                cyc_to = c;
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        int         hl, hr, cyc;
        logic [2:0] mid;
        logic       saw;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        sens     = '0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_speed", speed, 4);
        check("rst_crash", crash, 0);
        check("rst_timeout", timeout, 0);
        check("rst_pwm", {pwm_l, pwm_r}, 0);
        check("rst_dir", {dir_l, dir_r}, 3);
        rst = 1'b0;

        send(8'h71);
        check("fwd_state", state, 1);
        @(negedge clk);
        check("fwd_dir", {dir_l, dir_r}, 3);
        measure(8'h71, hl, hr);
        check("fwd_duty128_l", hl, 128);
        check("fwd_duty128_r", hr, 128);

        repeat (8) send(8'h2B);
        check("spd_max", speed, 7);
        check("spd_max_state", state, 1);
        measure(8'h71, hl, hr);
        check("fwd_duty224_l", hl, 224);
        check("fwd_duty224_r", hr, 224);
        repeat (10) send(8'h2D);
        check("spd_min", speed, 1);
        check("spd_min_state", state, 1);
        measure(8'h71, hl, hr);
        check("fwd_duty32_l", hl, 32);

        crash_pulse(2'b10);
        send(8'h71);
        check("crash_fwd_ign_state", state, 0);
        check("crash_fwd_ign_crash", crash, 1);
        send(8'h20);
        check("crash_estop_crash", crash, 1);
        send(8'h77);
        check("crash_clr", crash, 0);
        check("crash_bwd", state, 2);
        check("bwd_dir_n1", dir_l, 1);
        @(negedge clk);
        check("bwd_dir_n2", {dir_l, dir_r}, 0);

        // 0x77 landing on the crash-set edge is dropped
        send(8'h71);
        @(negedge clk);
        sens = 2'b01;
        @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        @(negedge clk);
        rx_valid = 1'b0;
        sens     = '0;
        check("same_cyc_crash", crash, 1);
        check("same_cyc_state", state, 0);
        @(negedge clk);
        check("same_cyc_no_replay", state, 0);
        send(8'h77);
        check("resend_bwd", state, 2);

        send(8'h65);
        @(negedge clk);
        measure(8'h65, hl, hr);
        check("left_pwm_l", hl, 0);
        check("left_pwm_r", hr, 32);

        wd_run(8'h65, -5, 8'h00, cyc, mid);
        check("wd_cycles", cyc, 100);
        check("wd_state", state, 0);
        @(posedge clk);
        #1;
        check("wd_pulse_one", timeout, 0);

        saw = 1'b0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h65;
        for (int i = 1; i <= 220; i++) begin
            @(negedge clk);
            saw |= timeout;
            if (i % 50 == 0) begin
                rx_valid = 1'b1;
                rx_data  = 8'h2B;
            end else begin
                rx_valid = 1'b0;
            end
        end
        rx_valid = 1'b0;
        check("kick_no_timeout", saw, 0);
        check("kick_state", state, 3);
        check("kick_speed", speed, 5);

        wd_run(8'h72, 60, 8'h41, cyc, mid);
        check("unk_state", mid, 4);
        check("unk_no_reload", cyc, 100);

        send(8'h71);
        crash_pulse(2'b11);
        send(8'h72);
        check("pre_rst_state", state, 4);
        check("pre_rst_crash", crash, 1);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        @(negedge clk);
        check("mid_rst_state", state, 0);
        check("mid_rst_speed", speed, 4);
        check("mid_rst_crash", crash, 0);
        check("mid_rst_outs", {timeout, pwm_l, pwm_r, dir_l, dir_r}, 3);
        rst      = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_state", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
